// File: rtl/kbd_cmd_pkg.sv
// Shared key codes, command encoding and state encoding for the keyboard
// command scheduler.
package kbd_cmd_pkg;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;
  localparam logic [7:0] KEY_P     = 8'h70;
  localparam logic [7:0] KEY_R     = 8'h72;
  localparam logic [7:0] KEY_ESC   = 8'h1B;

  typedef enum logic [1:0] {
    CMD_UP    = 2'd0,
    CMD_DOWN  = 2'd1,
    CMD_LEFT  = 2'd2,
    CMD_RIGHT = 2'd3
  } cmd_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  // Arrow codes occupy 0x80..0x83, so the low two bits are the command.
  function automatic logic is_arrow(input logic [7:0] code);
    return (code[7:2] == 6'b100000);
  endfunction

  function automatic cmd_t arrow_to_cmd(input logic [7:0] code);
    return cmd_t'(code[1:0]);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of 2-bit movement commands with flush and a
// registered occupancy count. Pop on empty is ignored.
module cmd_fifo
  import kbd_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [1:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [1:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic          full_s;
  logic          empty_s;

  // Qualify push/pop; a full queue still accepts a push when it is popped in the same cycle.
  always_comb begin
    full_s    = (count_r == (AW+1)'(DEPTH));
    empty_s   = (count_r == '0);
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 2'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign level = count_r;

endmodule

// File: rtl/frame_cmd_scheduler.sv
// Synchronizes keyboard events, decodes them into queued movement commands
// and releases at most one command per video frame on the vsync fall.
module frame_cmd_scheduler
  import kbd_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_new,
  input  logic [7:0]   key_ascii,
  input  logic         v_sync,
  output logic         move_up,
  output logic         move_down,
  output logic         move_left,
  output logic         move_right,
  output logic         paused,
  output logic [7:0]   last_key,
  output logic         overflow,
  output logic [AW:0]  fifo_level
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   key_prev_r;
  logic                   v_sync_q_r;
  state_t                 state_r;
  logic                   paused_r;
  logic [7:0]             last_key_r;
  logic                   overflow_r;
  logic                   move_up_r;
  logic                   move_down_r;
  logic                   move_left_r;
  logic                   move_right_r;

  logic                   key_edge_s;
  logic                   frame_tick_s;
  logic                   esc_s;
  logic                   pause_s;
  logic                   resume_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   drop_s;
  logic [1:0]             head_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [AW:0]            fifo_level_s;

  // Synchronizer chain, edge history and vsync history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r     <= '0;
      key_prev_r <= 1'b0;
      v_sync_q_r <= 1'b1;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], key_new};
      key_prev_r <= sync_r[SYNC_STAGES-1];
      v_sync_q_r <= v_sync;
    end
  end

  // Event decode; ESC and 'p' on a frame boundary suppress that frame's dispatch.
  always_comb begin
    key_edge_s   = sync_r[SYNC_STAGES-1] & ~key_prev_r;
    frame_tick_s = v_sync_q_r & ~v_sync;
    esc_s        = key_edge_s & (key_ascii == KEY_ESC);
    pause_s      = key_edge_s & (key_ascii == KEY_P);
    resume_s     = key_edge_s & (key_ascii == KEY_R);
    push_s       = key_edge_s & is_arrow(key_ascii) & (state_r == ST_RUN);
    pop_s        = frame_tick_s & (state_r == ST_RUN) & ~fifo_empty_s & ~esc_s & ~pause_s;
    drop_s       = push_s & fifo_full_s & ~pop_s;
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push_s),
    .push_data (arrow_to_cmd(key_ascii)),
    .pop       (pop_s),
    .flush     (esc_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // Mode FSM with registered mode, key, overflow and command-pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_RUN;
      paused_r     <= 1'b0;
      last_key_r   <= 8'h00;
      overflow_r   <= 1'b0;
      move_up_r    <= 1'b0;
      move_down_r  <= 1'b0;
      move_left_r  <= 1'b0;
      move_right_r <= 1'b0;
    end else begin
      if (key_edge_s) last_key_r <= key_ascii;
      else            last_key_r <= last_key_r;

      case (state_r)
        ST_RUN: begin
          if (pause_s) begin
            state_r  <= ST_PAUSED;
            paused_r <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (resume_s || esc_s) begin
            state_r  <= ST_RUN;
            paused_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_RUN;
          paused_r <= 1'b0;
        end
      endcase

      if (esc_s)       overflow_r <= 1'b0;
      else if (drop_s) overflow_r <= 1'b1;
      else             overflow_r <= overflow_r;

      move_up_r    <= pop_s & (head_s == CMD_UP);
      move_down_r  <= pop_s & (head_s == CMD_DOWN);
      move_left_r  <= pop_s & (head_s == CMD_LEFT);
      move_right_r <= pop_s & (head_s == CMD_RIGHT);
    end
  end

  assign move_up    = move_up_r;
  assign move_down  = move_down_r;
  assign move_left  = move_left_r;
  assign move_right = move_right_r;
  assign paused     = paused_r;
  assign last_key   = last_key_r;
  assign overflow   = overflow_r;
  assign fifo_level = fifo_level_s;

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Directed self-checking bench for frame_cmd_scheduler (FIFO_DEPTH=4,
// SYNC_STAGES=2); inputs change and outputs are sampled on the falling edge.
module tb_frame_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_new = 1'b0;
  logic [7:0] key_ascii = 8'h00;
  logic       v_sync = 1'b1;
  logic       move_up, move_down, move_left, move_right;
  logic       paused;
  logic [7:0] last_key;
  logic       overflow;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] cap1, cap2;

  frame_cmd_scheduler #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_new    (key_new),
    .key_ascii  (key_ascii),
    .v_sync     (v_sync),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .paused     (paused),
    .last_key   (last_key),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] moves();
    return {move_up, move_down, move_left, move_right};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One key event: hold long enough to be detected, then low long enough to re-arm.
  task automatic press(input logic [7:0] code);
    @(negedge clk);
    key_ascii = code;
    key_new   = 1'b1;
    repeat (3) @(negedge clk);
    key_new = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One vsync fall; c1 = pulses the cycle after the tick, c2 = the cycle after that.
  task automatic vsync_fall(output logic [3:0] c1, output logic [3:0] c2);
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    c1 = moves();
    v_sync = 1'b1;
    @(negedge clk);
    c2 = moves();
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_moves", moves(), 4'b0000);
    check("rst_paused", paused, 1'b0);
    check("rst_last_key", last_key, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Queue UP, UP, LEFT and release them over four frames.
    press(8'h80);
    press(8'h80);
    press(8'h82);
    check("q3_level", fifo_level, 3'd3);
    check("q3_last_key", last_key, 8'h82);
    vsync_fall(cap1, cap2);
    check("f1_pulse", cap1, 4'b1000);
    check("f1_after", cap2, 4'b0000);
    check("f1_level", fifo_level, 3'd2);
    vsync_fall(cap1, cap2);
    check("f2_pulse", cap1, 4'b1000);
    check("f2_after", cap2, 4'b0000);
    vsync_fall(cap1, cap2);
    check("f3_pulse", cap1, 4'b0010);
    check("f3_after", cap2, 4'b0000);
    check("f3_level", fifo_level, 3'd0);
    vsync_fall(cap1, cap2);
    check("f4_pulse", cap1, 4'b0000);

    // Overflow with five DOWN keys, then ESC flush.
    for (int i = 0; i < 5; i++) press(8'h81);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_last_key", last_key, 8'h81);
    press(8'h1B);
    check("esc_level", fifo_level, 3'd0);
    check("esc_overflow", overflow, 1'b0);
    check("esc_last_key", last_key, 8'h1B);

    // Pause retains the queue; resume lets it drain.
    press(8'h83);
    press(8'h70);
    check("pause_flag", paused, 1'b1);
    vsync_fall(cap1, cap2);
    check("pause_f1", cap1, 4'b0000);
    vsync_fall(cap1, cap2);
    check("pause_f2", cap1, 4'b0000);
    check("pause_level", fifo_level, 3'd1);
    press(8'h81);
    check("pause_drop_level", fifo_level, 3'd1);
    press(8'h72);
    check("resume_flag", paused, 1'b0);
    vsync_fall(cap1, cap2);
    check("resume_pulse", cap1, 4'b0001);
    check("resume_level", fifo_level, 3'd0);

    // Push coinciding with the frame-tick pop while one entry is queued.
    press(8'h80);
    @(negedge clk);
    key_ascii = 8'h81;
    key_new   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    check("same_pulse", moves(), 4'b1000);
    check("same_level", fifo_level, 3'd1);
    v_sync = 1'b1;
    @(negedge clk);
    check("same_after", moves(), 4'b0000);
    key_new = 1'b0;
    repeat (3) @(negedge clk);
    vsync_fall(cap1, cap2);
    check("same_next", cap1, 4'b0100);
    check("same_empty", fifo_level, 3'd0);

    // A held key is a single event.
    @(negedge clk);
    key_ascii = 8'h41;
    key_new   = 1'b1;
    repeat (1000) @(negedge clk);
    key_new = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_last_key", last_key, 8'h41);
    check("hold_level", fifo_level, 3'd0);
    @(negedge clk);
    key_ascii = 8'h80;
    key_new   = 1'b1;
    repeat (100) @(negedge clk);
    key_new = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_arrow_level", fifo_level, 3'd1);
    press(8'h1B);

    // Asynchronous reset in the middle of a pulse with entries still queued.
    press(8'h80);
    press(8'h82);
    check("prerst_level", fifo_level, 3'd2);
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    check("prerst_pulse", moves(), 4'b1000);
    reset = 1'b1;
    #1;
    check("arst_moves", moves(), 4'b0000);
    check("arst_level", fifo_level, 3'd0);
    check("arst_last_key", last_key, 8'h00);
    v_sync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vsync_fall(cap1, cap2);
    check("postrst_pulse", cap1, 4'b0000);
    check("postrst_level", fifo_level, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
